uart_tx_serializer: RTL and testbench

// Serial transmitter that consumes the JSON command byte stream from the command translator and

---
 rtl/uart_tx_serializer_if.sv | 26 ++
 rtl/uart_tx_serializer.sv | 152 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
// Byte handshake between the command translator (master) and the UART
// transmitter (slave). A byte moves on any clock edge where tx_valid and
// tx_ready are both high.
//   tx_data  : byte to send (master -> slave)
//   tx_valid : tx_data is valid (master -> slave)
//   tx_ready : transmitter holding register is empty (slave -> master)
// ---------------------------------------------------------------------------
interface uart_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop
// bit. A one-byte holding register accepts the next byte while the current
// frame shifts out, so consecutive frames leave with no idle gap.
// Ports:
//   clk      : system clock, all logic on posedge
//   reset_n  : asynchronous active-low reset
//   up       : byte handshake (tx_data / tx_valid in, tx_ready out)
//   tx       : registered serial line, idles high
//   tx_busy  : high while a frame is on the line or a byte is held
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_tx_serializer_if.slave   up,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_rate
            $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         hold_data_q, hold_data_d;
    logic               hold_valid_q, hold_valid_d;
    logic               tx_q, tx_d;

    logic               bit_end;
    logic               accept;

    assign bit_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    // Accept only into an empty holding register; a reload always happens
    // while the register is full, so the two can never collide.
    assign accept  = up.tx_valid && !hold_valid_q;

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        tx_d         = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (hold_valid_q) begin
                    shift_d      = hold_data_q;
                    hold_valid_d = 1'b0;
                    baud_d       = '0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (hold_valid_q) begin
                        // Back-to-back: next start bit follows the stop bit directly.
                        shift_d      = hold_data_q;
                        hold_valid_d = 1'b0;
                        state_d      = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            hold_data_d  = up.tx_data;
            hold_valid_d = 1'b1;
        end

        // The line level is computed from the next state so tx can be a
        // plain register and still change on the same edge as the state.
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            hold_data_q  <= 8'h00;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
        end
    end

    assign up.tx_ready = !hold_valid_q;
    assign tx          = tx_q;
    assign tx_busy     = (state_q != S_IDLE) || hold_valid_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
// Scoreboard bench for the 8N1 transmitter at 16 clocks per bit. Every
// accepted byte is turned into an expected frame (data plus the clock on
// which its start bit must appear) from the line rules: a frame starts one
// clock after acceptance, or right after the previous frame if the line is
// still busy, and lasts 10 bit times. A line monitor decodes frames and
// compares them against the queue; a per-cycle checker compares tx,
// tx_busy and tx_ready with the same expected-frame list.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic reset_n;
    logic tx;
    logic tx_busy;

    uart_tx_serializer_if u_if ();

    uart_tx_serializer #(
        .CLK_FREQ_HZ (16),
        .BAUD        (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .up      (u_if),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; read only on falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         acc;
        int         start;
    } xfer_t;

    xfer_t sb_q[$];
    xfer_t act_q[$];
    int    line_free   = 0;
    int    last_start  = 0;
    int    n_cmp       = 0;
    int    n_err       = 0;
    int    frames_seen = 0;
    int    trace_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: schedule a frame for a byte accepted on edge acc.
    task automatic model_accept(input logic [7:0] d, input int acc);
        xfer_t e;
        e.data  = d;
        e.acc   = acc;
        e.start = (acc + 1 > line_free) ? acc + 1 : line_free;
        line_free  = e.start + FRAME;
        last_start = e.start;
        sb_q.push_back(e);
        act_q.push_back(e);
    endtask

    task automatic model_reset();
        sb_q.delete();
        act_q.delete();
        line_free = 0;
    endtask

    // Called just after a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [7:0] b, input bit keep_valid);
        int waited = 0;
        bit done   = 1'b0;
        u_if.tx_data  = b;
        u_if.tx_valid = 1'b1;
        while (!done) begin
            if (u_if.tx_ready === 1'b1) begin
                model_accept(b, cyc + 1);
                $display("send 0x%02h accepted at edge %0d, frame due at %0d", b, cyc + 1, last_start);
                done = 1'b1;
            end
            @(negedge clk);
            waited++;
            if (!done && waited > 4 * FRAME) begin
                check("accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        if (!keep_valid) u_if.tx_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic end_test(input string name, input int exp_frames);
        wait_cyc(line_free + 2);
        check({name, "_trace_bad_cycles"}, trace_bad, 0);
        check({name, "_frames"}, frames_seen, exp_frames);
        check({name, "_sb_empty"}, sb_q.size(), 0);
        trace_bad   = 0;
        frames_seen = 0;
    endtask

    // Per-cycle check of tx / tx_busy / tx_ready against the scheduled frames.
    initial begin : trace_chk
        logic eh, ef, etx;
        int   k;
        forever begin
            @(negedge clk);
            eh  = 1'b0;
            ef  = 1'b0;
            etx = 1'b1;
            foreach (act_q[i]) begin
                if (act_q[i].acc <= cyc && cyc < act_q[i].start) eh = 1'b1;
                if (act_q[i].start <= cyc && cyc < act_q[i].start + FRAME) begin
                    ef = 1'b1;
                    k  = (cyc - act_q[i].start) / CPB;
                    if (k == 0)      etx = 1'b0;
                    else if (k == 9) etx = 1'b1;
                    else             etx = act_q[i].data[k-1];
                end
            end
            if (tx !== etx || tx_busy !== (eh | ef) || u_if.tx_ready !== ~eh) trace_bad++;
            while (act_q.size() > 0 && act_q[0].start + FRAME < cyc) void'(act_q.pop_front());
        end
    end

    // Line monitor: decode frames mid-bit and compare with the scoreboard.
    initial begin : line_mon
        bit         active = 1'b0;
        int         s      = 0;
        int         off;
        logic [9:0] bits   = '0;
        xfer_t      e;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    s      = cyc;
                end
            end else begin
                off = cyc - s;
                if (off % CPB == CPB / 2) bits[off / CPB] = tx;
                if (off == FRAME - CPB / 2) begin
                    frames_seen++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        $display("frame 0x%02h started at %0d (expected 0x%02h at %0d)",
                                 bits[8:1], s, e.data, e.start);
                        check("frame_data", bits[8:1], e.data);
                        check("frame_start_cycle", s, e.start);
                        check("frame_start_stop_bits", {bits[9], bits[0]}, 2'b10);
                    end
                end
                if (off == FRAME - 1) active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        string cmd;
        int    ls;
        reset_n       = 1'b0;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        check("reset_tx", tx, 1);
        check("reset_tx_ready", u_if.tx_ready, 1);
        check("reset_tx_busy", tx_busy, 0);

        // Long idle with tx_valid low.
        wait_cyc(cyc + 1000);
        check("idle_tx", tx, 1);
        check("idle_busy", tx_busy, 0);
        check("idle_ready", u_if.tx_ready, 1);
        end_test("idle", 0);

        // Single byte, one-cycle valid pulse: line drops one clock after accept.
        send(8'h7B, 1'b0);
        check("t1_tx_high_on_accept", tx, 1);
        @(negedge clk);
        check("t1_tx_low_next_clk", tx, 0);
        end_test("t1", 1);
        check("t1_after_tx", tx, 1);
        check("t1_after_busy", tx_busy, 0);

        // Two bytes with valid held high: second waits in the holding register.
        send(8'h22, 1'b1);
        send(8'h54, 1'b0);
        check("t2_ready_low_while_held", u_if.tx_ready, 0);
        end_test("t2", 2);

        // Translator streaming the STOP command.
        cmd = "{\"T\":0,\"L\":00.00,\"R\":00.00}\n";
        for (int i = 0; i < cmd.len(); i++) send(cmd[i], i != cmd.len() - 1);
        wait_cyc(line_free - 1);
        check("t3_busy_before_last_stop_end", tx_busy, 1);
        @(negedge clk);
        check("t3_busy_after_last_stop_end", tx_busy, 0);
        end_test("t3", 28);

        // Reset in the middle of a frame.
        send(8'hA5, 1'b0);
        ls = last_start;
        wait_cyc(ls + 70);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("t4_tx_on_reset", tx, 1);
        check("t4_ready_on_reset", u_if.tx_ready, 1);
        check("t4_busy_on_reset", tx_busy, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        send(8'h3A, 1'b0);
        end_test("t4", 1);

        // Byte accepted exactly on the stop-bit end edge of the previous frame.
        send(8'hC3, 1'b0);
        ls = last_start;
        wait_cyc(ls + FRAME - 1);
        send(8'h5A, 1'b0);
        end_test("t6", 2);

        // Random bytes, random gaps and valid hold patterns.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                u_if.tx_valid = 1'b0;
                repeat ($urandom_range(1, 200)) @(negedge clk);
            end
            send(8'($urandom), 1'($urandom_range(0, 1)));
        end
        u_if.tx_valid = 1'b0;
        end_test("rand", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
